stream_group_accumulator: RTL and testbench
===========================================

// Module: stream_group_accumulator
// PURPOSE
//  Consumes a valid/ready stream and sums each run of GROUP consecutive elements into one result.
//  Sits directly downstream of single_element_repeat, where GROUP equals its REPEAT count,
//  to reduce repeated or broadcast partial terms back to one element per source element.
//  Output is registered; throughput is one input element per cycle with no bubble at group boundaries.
// PARAMETERS
//  IN_WIDTH   16   input element width, two's complement when SIGNED=1
//  GROUP      2    elements per group, >=1
//  SIGNED     1    1: sign-extend inputs; 0: zero-extend inputs
//  OUT_WIDTH  IN_WIDTH+$clog2(GROUP)   result width; localparam, not overridable
// PORTS
//  clk        in   1          clock; all state updates on posedge
//  rst        in   1          synchronous, active-high reset
//  in_data    in   IN_WIDTH   input element
//  in_valid   in   1          in_data valid
//  in_ready   out  1          block accepts in_data this cycle
//  in_last    in   1          early group terminator; port exists only with STREAM_GROUP_ACC_LAST_EN
//  out_data   out  OUT_WIDTH  group sum
//  out_valid  out  1          out_data valid
//  out_ready  in   1          downstream accepts out_data
// BEHAVIOUR
//  - State: acc[OUT_WIDTH], count[max(1,$clog2(GROUP))], out register {out_data, out_valid}.
//  - Reset: acc=0, count=0, out_data=0, out_valid=0. in_ready is combinational and goes 1 the cycle after reset.
//  - Accept when in_valid && in_ready. Extend in_data to OUT_WIDTH per SIGNED before adding.
//  - Closing element: count==GROUP-1, or in_last=1 when the macro is enabled.
//  - Non-closing accept: acc <= acc + ext(in_data) (acc is treated as 0 when count==0); count <= count+1.
//  - Closing accept: out_data <= acc + ext(in_data) (acc treated as 0 if count==0); out_valid <= 1;
//    acc <= 0; count <= 0.
//  - in_ready = !is_closing || !out_valid || out_ready. Non-closing elements never stall,
//    even while a result is held.
//  - Output register: out_valid clears on out_valid && out_ready unless a closing accept occurs
//    in the same cycle. In that case the new result overwrites and out_valid stays 1.
//  - out_data/out_valid hold stable while out_valid && !out_ready (AXI-style, no retraction).
//  - Latency: the result appears the cycle after the closing element is accepted.
//  - No overflow by construction: OUT_WIDTH holds GROUP*extreme input values, in both signed and
//    unsigned modes.
//  - GROUP==1: every element is closing; the block becomes a one-deep registered pipe with extension.
//  - Reset mid-group or with a held result: the partial sum and held result are discarded.
//    No output is produced for them.
//  - in_valid && !in_ready: no state change. in_data need not be held stable when not valid.
// CONFIGURATION
//  STREAM_GROUP_ACC_LAST_EN defined:
//    - in_last port present.
//    - An accepted element with in_last=1 closes the group early and emits the sum of 1..GROUP
//      elements.
//    - in_last on a count==GROUP-1 element behaves as a normal close.
//  Undefined:
//    - No in_last port; groups are always exactly GROUP elements.
// TESTING
//  1 GROUP=4, IN_WIDTH=8, SIGNED=1, out_ready=1; feed 1,2,3,4 back-to-back
//    -> out_data=10 one cycle after the 4th accept, out_valid high 1 cycle.
//  2 Same config; feed -128 x4 -> out_data=10'h200 (-512). SIGNED=0 with 255 x4 -> 1020.
//  3 out_ready=0 after group 1 result (10); feed 5,6,7,8
//    -> 5,6,7 accepted, in_ready=0 on 8 until out_ready=1;
//    then 8 accepted the same cycle 10 pops, next out_data=26.
//  4 Continuous in_valid with 8 elements of 1 and out_ready=1
//    -> in_ready never low, outputs 4,4 on cycles 5 and 9 after start.
//  5 Feed 1,1 then assert rst 1 cycle, then 3,3,3,3
//    -> out_valid=0 during and after reset, single result 12.
//  6 With STREAM_GROUP_ACC_LAST_EN: feed 5, then 6 with in_last=1, then 1,1,1,1
//    -> results 11 then 4. GROUP=1 check: 7 -> 7 one cycle later.

Source files
------------

// File: rtl/stream_group_accumulator.sv
// stream_group_accumulator: sums each run of GROUP consecutive stream
// elements into one registered result (valid/ready in and out).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_data/valid/ready input stream (in_ready is combinational)
//   in_last             early group close, only with STREAM_GROUP_ACC_LAST_EN
//   out_data/valid/ready registered group-sum output stream
//
// Optional feature macro: STREAM_GROUP_ACC_LAST_EN (adds in_last).
module stream_group_accumulator #(
    parameter int IN_WIDTH  = 16,
    parameter int GROUP     = 2,
    parameter bit SIGNED    = 1'b1,
    localparam int OUT_WIDTH = IN_WIDTH + $clog2(GROUP)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
`ifdef STREAM_GROUP_ACC_LAST_EN
    input  logic                 in_last,
`endif
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int CNT_W = (GROUP > 1) ? $clog2(GROUP) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GROUP - 1);

    logic [OUT_WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]     r_count;
    logic [OUT_WIDTH-1:0] r_out_data;
    logic                 r_out_valid;

    logic [OUT_WIDTH-1:0] w_ext;
    logic [OUT_WIDTH-1:0] w_sum;
    logic                 w_closing;
    logic                 w_accept;
    logic                 w_pop;

    always_comb begin
        if (SIGNED) begin
            w_ext = OUT_WIDTH'($signed(in_data));
        end else begin
            w_ext = OUT_WIDTH'(in_data);
        end
    end

    // The first element of a group starts from zero regardless of r_acc.
    assign w_sum = ((r_count == '0) ? '0 : r_acc) + w_ext;

`ifdef STREAM_GROUP_ACC_LAST_EN
    assign w_closing = (r_count == LAST_CNT) || in_last;
`else
    assign w_closing = (r_count == LAST_CNT);
`endif

    // Only a closing element needs the output register; partial sums
    // keep flowing while a result is held.
    assign in_ready = !w_closing || !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_pop    = r_out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_count     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_pop) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                if (w_closing) begin
                    // Overrides the pop above: new result replaces the old.
                    r_out_data  <= w_sum;
                    r_out_valid <= 1'b1;
                    r_acc       <= '0;
                    r_count     <= '0;
                end else begin
                    r_acc   <= w_sum;
                    r_count <= r_count + CNT_W'(1);
                end
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_stream_group_accumulator.sv
// Directed scoreboard bench for stream_group_accumulator.
// Instances: GROUP=4 signed, GROUP=4 unsigned, GROUP=1 signed (IN_WIDTH=8).
module tb_stream_group_accumulator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       vs = 1'b0, vu = 1'b0, vg = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b1;

    logic       rdy_s, rdy_u, rdy_g;
    logic [9:0] od_s, od_u;
    logic [7:0] od_g;
    logic       ov_s, ov_u, ov_g;

    int checks = 0;
    int failures = 0;

    logic [9:0] qs[$];
    logic [9:0] qu[$];
    logic [7:0] qg[$];

    always #5 clk = ~clk;

    stream_group_accumulator #(.IN_WIDTH(8), .GROUP(4), .SIGNED(1'b1)) u_s (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(vs),
        .in_ready(rdy_s),
`ifdef STREAM_GROUP_ACC_LAST_EN
        .in_last(in_last),
`endif
        .out_data(od_s), .out_valid(ov_s), .out_ready(out_ready)
    );

    stream_group_accumulator #(.IN_WIDTH(8), .GROUP(4), .SIGNED(1'b0)) u_u (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(vu),
        .in_ready(rdy_u),
`ifdef STREAM_GROUP_ACC_LAST_EN
        .in_last(1'b0),
`endif
        .out_data(od_u), .out_valid(ov_u), .out_ready(out_ready)
    );

    stream_group_accumulator #(.IN_WIDTH(8), .GROUP(1), .SIGNED(1'b1)) u_g (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(vg),
        .in_ready(rdy_g),
`ifdef STREAM_GROUP_ACC_LAST_EN
        .in_last(1'b0),
`endif
        .out_data(od_g), .out_valid(ov_g), .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int sel);
        case (sel)
            0: return rdy_s;
            1: return rdy_u;
            default: return rdy_g;
        endcase
    endfunction

    task automatic set_valid(input int sel, input logic v);
        case (sel)
            0: vs = v;
            1: vu = v;
            default: vg = v;
        endcase
    endtask

    // Drive one element; returns the number of stalled cycles.
    task automatic send(input int sel, input logic [7:0] d,
                        input logic l, output int waits);
        waits = 0;
        in_data = d;
        in_last = l;
        set_valid(sel, 1'b1);
        @(negedge clk);
        while (rdy(sel) !== 1'b1 && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        if (waits >= 100) check("send_timeout", 32'(waits), 32'd0);
        @(posedge clk);
        #1;
        set_valid(sel, 1'b0);
        in_last = 1'b0;
        in_data = 8'hxx;
    endtask

    // Scoreboard monitors: pop on each output handshake.
    always @(negedge clk) begin
        if (!rst && ov_s && out_ready) begin
            if (qs.size() == 0) check("s_unexpected", {22'b0, od_s}, 32'hx);
            else check("s_result", {22'b0, od_s}, {22'b0, qs.pop_front()});
        end
        if (!rst && ov_u && out_ready) begin
            if (qu.size() == 0) check("u_unexpected", {22'b0, od_u}, 32'hx);
            else check("u_result", {22'b0, od_u}, {22'b0, qu.pop_front()});
        end
        if (!rst && ov_g && out_ready) begin
            if (qg.size() == 0) check("g_unexpected", {24'b0, od_g}, 32'hx);
            else check("g_result", {24'b0, od_g}, {24'b0, qg.pop_front()});
        end
    end

    initial begin
        int w;
        // Reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_out_valid", {31'b0, ov_s}, 32'd0);
        check("rst_out_data", {22'b0, od_s}, 32'd0);
        check("rst_in_ready", {31'b0, rdy_s}, 32'd1);

        // 1: 1,2,3,4 -> 10, valid for one cycle
        qs.push_back(10'd10);
        send(0, 8'd1, 1'b0, w);
        send(0, 8'd2, 1'b0, w);
        send(0, 8'd3, 1'b0, w);
        check("t1_early_valid", {31'b0, ov_s}, 32'd0);
        send(0, 8'd4, 1'b0, w);
        check("t1_valid", {31'b0, ov_s}, 32'd1);
        check("t1_data", {22'b0, od_s}, 32'd10);
        @(posedge clk); #1;
        check("t1_valid_drop", {31'b0, ov_s}, 32'd0);

        // 2: signed extremes and unsigned extremes
        qs.push_back(10'h200);
        repeat (4) send(0, 8'h80, 1'b0, w);
        qu.push_back(10'd1020);
        repeat (4) send(1, 8'hFF, 1'b0, w);
        check("t2_u_data", {22'b0, od_u}, 32'd1020);

        // 3: backpressure on closing element only
        out_ready = 1'b0;
        qs.push_back(10'd10);
        send(0, 8'd1, 1'b0, w);
        send(0, 8'd2, 1'b0, w);
        send(0, 8'd3, 1'b0, w);
        send(0, 8'd4, 1'b0, w);
        send(0, 8'd5, 1'b0, w);
        check("t3_no_stall5", 32'(w), 32'd0);
        send(0, 8'd6, 1'b0, w);
        check("t3_no_stall6", 32'(w), 32'd0);
        send(0, 8'd7, 1'b0, w);
        check("t3_no_stall7", 32'(w), 32'd0);
        qs.push_back(10'd26);
        in_data = 8'd8;
        vs = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_stall", {31'b0, rdy_s}, 32'd0);
            check("t3_hold", {21'b0, ov_s, od_s}, {21'b0, 1'b1, 10'd10});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_release", {31'b0, rdy_s}, 32'd1);
        @(posedge clk); #1;
        vs = 1'b0;
        check("t3_next", {21'b0, ov_s, od_s}, {21'b0, 1'b1, 10'd26});
        @(posedge clk); #1;

        // 4: eight ones back-to-back, no stalls
        qs.push_back(10'd4);
        qs.push_back(10'd4);
        for (int i = 0; i < 8; i++) begin
            send(0, 8'd1, 1'b0, w);
            check("t4_no_stall", 32'(w), 32'd0);
            if (i == 3 || i == 7)
                check("t4_out", {21'b0, ov_s, od_s}, {21'b0, 1'b1, 10'd4});
        end
        @(posedge clk); #1;

        // 5: reset discards a partial group
        send(0, 8'd1, 1'b0, w);
        send(0, 8'd1, 1'b0, w);
        rst = 1'b1;
        @(negedge clk);
        check("t5_in_rst", {31'b0, ov_s}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5_after_rst", {31'b0, ov_s}, 32'd0);
        qs.push_back(10'd12);
        repeat (4) send(0, 8'd3, 1'b0, w);
        check("t5_data", {22'b0, od_s}, 32'd12);

`ifdef STREAM_GROUP_ACC_LAST_EN
        // 6: early close via in_last
        qs.push_back(10'd11);
        qs.push_back(10'd4);
        send(0, 8'd5, 1'b0, w);
        send(0, 8'd6, 1'b1, w);
        check("t6_last", {21'b0, ov_s, od_s}, {21'b0, 1'b1, 10'd11});
        repeat (4) send(0, 8'd1, 1'b0, w);
        check("t6_after", {22'b0, od_s}, 32'd4);
`endif

        // GROUP=1 pipe
        qg.push_back(8'd7);
        send(2, 8'd7, 1'b0, w);
        check("g1_out", {23'b0, ov_g, od_g}, {23'b0, 1'b1, 8'd7});
        qg.push_back(8'hFE);
        send(2, 8'hFE, 1'b0, w);
        check("g1_neg", {24'b0, od_g}, 32'hFE);

        repeat (3) @(posedge clk);
        #1;
        check("qs_drained", 32'(qs.size()), 32'd0);
        check("qu_drained", 32'(qu.size()), 32'd0);
        check("qg_drained", 32'(qg.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
